// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and the 3-tap vote.
// Used by both the receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Serial line synchroniser, per-bit clock counter and 3-sample majority vote.
// Emits one strobe per bit period, one cycle after the last vote tap.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Rx_Serial,
    input  logic i_Restart,
    output logic o_Line,
    output logic o_Sample_Stb,
    output logic o_Sample_Bit
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);

    logic             rx_sync_p0;
    logic             rx_sync_p1;
    logic [CNT_W-1:0] clk_cnt;
    logic             tap_lo;
    logic             tap_mid;

    // The counter rolls over at every bit boundary, so once it is zeroed on the
    // start edge each following bit is voted on at the same mid-bit offsets.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            clk_cnt    <= '0;
            tap_lo     <= 1'b1;
            tap_mid    <= 1'b1;
        end else begin
            rx_sync_p0 <= i_Rx_Serial;
            rx_sync_p1 <= rx_sync_p0;

            if (i_Restart || clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (clk_cnt == CNT_MID_M1) begin
                tap_lo <= rx_sync_p1;
            end
            if (clk_cnt == CNT_MID) begin
                tap_mid <= rx_sync_p1;
            end
        end
    end

    assign o_Line       = rx_sync_p1;
    assign o_Sample_Stb = (clk_cnt == CNT_MID_P1) && !i_Restart;
    assign o_Sample_Bit = majority3(tap_lo, tap_mid, rx_sync_p1);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, parity and stop bits, with
// majority-voted sampling plus parity, framing and break detection.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_Dv,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] data_sr;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par_err_acc;
    logic                 frame_err_acc;
    logic                 all_zero;
    logic                 wait_high;

    logic line;
    logic sample_stb;
    logic sample_bit;
    logic sample_clr;
    logic stop_last;
    logic frame_now;
    logic zero_now;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == PAR_ODD) ? ~x : x;
    endfunction

    assign sample_clr = (state == ST_IDLE);
    assign stop_last  = (STOP_BITS == 1) || stop_idx;
    assign frame_now  = frame_err_acc | ~sample_bit;
    assign zero_now   = all_zero & ~sample_bit;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Rx_Serial (i_Rx_Serial),
        .i_Restart   (sample_clr),
        .o_Line      (line),
        .o_Sample_Stb(sample_stb),
        .o_Sample_Bit(sample_bit)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state         <= ST_IDLE;
            data_sr       <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
            all_zero      <= 1'b0;
            wait_high     <= 1'b0;
            o_Rx_Dv       <= 1'b0;
            o_Rx_Byte     <= '0;
            o_Parity_Err  <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_Break       <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Rx_Dv <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // After a break the line must go high before a new start edge counts.
                    if (wait_high) begin
                        if (line) begin
                            wait_high <= 1'b0;
                        end
                    end else if (!line) begin
                        state  <= ST_START;
                        o_Busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (sample_stb) begin
                        if (!sample_bit) begin
                            state         <= ST_DATA;
                            bit_idx       <= '0;
                            stop_idx      <= 1'b0;
                            par_err_acc   <= 1'b0;
                            frame_err_acc <= 1'b0;
                            all_zero      <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            o_Busy <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (sample_stb) begin
                        data_sr[bit_idx] <= sample_bit;
                        all_zero         <= zero_now;
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (sample_stb) begin
                        par_err_acc <= parity_error(data_sr, sample_bit);
                        all_zero    <= zero_now;
                        state       <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (sample_stb) begin
                        if (stop_last) begin
                            state        <= ST_DONE;
                            o_Rx_Dv      <= 1'b1;
                            o_Rx_Byte    <= zero_now ? '0 : data_sr;
                            o_Parity_Err <= par_err_acc;
                            o_Frame_Err  <= frame_now | zero_now;
                            o_Break      <= zero_now;
                            wait_high    <= zero_now;
                        end else begin
                            stop_idx      <= 1'b1;
                            frame_err_acc <= frame_now;
                            all_zero      <= zero_now;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances cover 8N1, 7E1 and 8N2
// framing; each scenario task drives its serial line and checks outputs inline.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    logic rx [3];

    logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
    logic [6:0] byte_b;
    logic       dv_c, perr_c, ferr_c, brk_c, busy_c;
    logic [7:0] byte_c;

    int n_checks = 0;
    int n_errors = 0;
    int n_dv_a = 0;
    int n_dv_b = 0;
    int n_dv_c = 0;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[0]),
        .o_Rx_Dv(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Busy(busy_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[1]),
        .o_Rx_Dv(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Busy(busy_b)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[2]),
        .o_Rx_Dv(dv_c), .o_Rx_Byte(byte_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_Break(brk_c), .o_Busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dv_a) n_dv_a++;
        if (dv_b) n_dv_b++;
        if (dv_c) n_dv_c++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit period; optionally inverts the line for a single cycle at offset glitch_at.
    task automatic send_bit(input int w, input logic v, input int glitch_at);
        for (int i = 0; i < CPB; i++) begin
            rx[w] = (i == glitch_at) ? ~v : v;
            tick(1);
        end
    endtask

    task automatic send_frame(input int w, input logic [8:0] data, input int nbits,
                              input int par, input int nstops, input logic last_stop,
                              input int glitch_bit);
        send_bit(w, 1'b0, -1);
        for (int b = 0; b < nbits; b++) begin
            send_bit(w, data[b], (b == glitch_bit) ? 8 : -1);
        end
        if (par >= 0) send_bit(w, par[0], -1);
        for (int s = 0; s < nstops; s++) begin
            send_bit(w, (s == nstops - 1) ? last_stop : 1'b1, -1);
        end
        rx[w] = 1'b1;
    endtask

    task automatic test_reset();
        rx[0] = 1'b1; rx[1] = 1'b1; rx[2] = 1'b1;
        rst_n = 1'b0;
        tick(3);
        n_checks++;
        if ({dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
            n_errors++; $display("FAIL reset_a: got %b expected 0", {dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a});
        end
        n_checks++;
        if ({dv_b, byte_b, perr_b, ferr_b, brk_b, busy_b} !== 12'd0) begin
            n_errors++; $display("FAIL reset_b: got %b expected 0", {dv_b, byte_b, perr_b, ferr_b, brk_b, busy_b});
        end
        n_checks++;
        if ({dv_c, byte_c, perr_c, ferr_c, brk_c, busy_c} !== 13'd0) begin
            n_errors++; $display("FAIL reset_c: got %b expected 0", {dv_c, byte_c, perr_c, ferr_c, brk_c, busy_c});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_8n1();
        int d0;
        d0 = n_dv_a;
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, -1);
        tick(3);
        n_checks++;
        if (n_dv_a - d0 != 1) begin
            n_errors++; $display("FAIL a5_strobes: got %0d expected 1", n_dv_a - d0);
        end
        n_checks++;
        if (byte_a !== 8'hA5) begin
            n_errors++; $display("FAIL a5_byte: got %h expected a5", byte_a);
        end
        n_checks++;
        if ({perr_a, ferr_a, brk_a} !== 3'b000) begin
            n_errors++; $display("FAIL a5_flags: got %b expected 000", {perr_a, ferr_a, brk_a});
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_errors++; $display("FAIL a5_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_parity();
        int d0;
        d0 = n_dv_b;
        send_frame(1, 9'h041, 7, 0, 1, 1'b1, -1);
        tick(3);
        n_checks++;
        if (n_dv_b - d0 != 1) begin
            n_errors++; $display("FAIL par_ok_strobes: got %0d expected 1", n_dv_b - d0);
        end
        n_checks++;
        if (byte_b !== 7'h41) begin
            n_errors++; $display("FAIL par_ok_byte: got %h expected 41", byte_b);
        end
        n_checks++;
        if ({perr_b, ferr_b, brk_b} !== 3'b000) begin
            n_errors++; $display("FAIL par_ok_flags: got %b expected 000", {perr_b, ferr_b, brk_b});
        end
        send_frame(1, 9'h041, 7, 1, 1, 1'b1, -1);
        tick(3);
        n_checks++;
        if (n_dv_b - d0 != 2) begin
            n_errors++; $display("FAIL par_bad_strobes: got %0d expected 2", n_dv_b - d0);
        end
        n_checks++;
        if (byte_b !== 7'h41) begin
            n_errors++; $display("FAIL par_bad_byte: got %h expected 41", byte_b);
        end
        n_checks++;
        if ({perr_b, ferr_b, brk_b} !== 3'b100) begin
            n_errors++; $display("FAIL par_bad_flags: got %b expected 100", {perr_b, ferr_b, brk_b});
        end
    endtask

    task automatic test_8n2();
        int d0;
        d0 = n_dv_c;
        send_frame(2, 9'h0C3, 8, -1, 2, 1'b1, -1);
        tick(3);
        n_checks++;
        if (byte_c !== 8'hC3 || ferr_c !== 1'b0) begin
            n_errors++; $display("FAIL n2_good: got byte %h ferr %b expected c3 0", byte_c, ferr_c);
        end
        send_frame(2, 9'h05A, 8, -1, 2, 1'b0, -1);
        tick(3 * CPB);
        n_checks++;
        if (n_dv_c - d0 != 2) begin
            n_errors++; $display("FAIL n2_strobes: got %0d expected 2", n_dv_c - d0);
        end
        n_checks++;
        if (byte_c !== 8'h5A) begin
            n_errors++; $display("FAIL n2_byte: got %h expected 5a", byte_c);
        end
        n_checks++;
        if ({perr_c, ferr_c, brk_c} !== 3'b010) begin
            n_errors++; $display("FAIL n2_flags: got %b expected 010", {perr_c, ferr_c, brk_c});
        end
    endtask

    task automatic test_glitch();
        int d0;
        d0 = n_dv_a;
        rx[0] = 1'b0;
        tick(4);
        rx[0] = 1'b1;
        tick(3 * CPB);
        n_checks++;
        if (n_dv_a != d0 || busy_a !== 1'b0) begin
            n_errors++; $display("FAIL glitch_reject: got strobes %0d busy %b expected 0 0", n_dv_a - d0, busy_a);
        end
        send_frame(0, 9'h0FF, 8, -1, 1, 1'b1, 3);
        tick(3);
        n_checks++;
        if (n_dv_a - d0 != 1 || byte_a !== 8'hFF) begin
            n_errors++; $display("FAIL glitch_vote: got strobes %0d byte %h expected 1 ff", n_dv_a - d0, byte_a);
        end
    endtask

    task automatic test_break();
        int d0;
        d0 = n_dv_a;
        rx[0] = 1'b0;
        tick(12 * CPB);
        n_checks++;
        if (n_dv_a - d0 != 1) begin
            n_errors++; $display("FAIL brk_strobes: got %0d expected 1", n_dv_a - d0);
        end
        n_checks++;
        if ({brk_a, ferr_a, perr_a} !== 3'b110 || byte_a !== 8'h00) begin
            n_errors++; $display("FAIL brk_flags: got brk/ferr/perr %b byte %h expected 110 00", {brk_a, ferr_a, perr_a}, byte_a);
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_errors++; $display("FAIL brk_hold_idle: got busy %b expected 0", busy_a);
        end
        rx[0] = 1'b1;
        tick(2 * CPB);
        n_checks++;
        if (n_dv_a - d0 != 1) begin
            n_errors++; $display("FAIL brk_no_refire: got %0d expected 1", n_dv_a - d0);
        end
        send_frame(0, 9'h03C, 8, -1, 1, 1'b1, -1);
        tick(3);
        n_checks++;
        if (byte_a !== 8'h3C || {brk_a, ferr_a} !== 2'b00 || n_dv_a - d0 != 2) begin
            n_errors++; $display("FAIL brk_recover: got byte %h brk/ferr %b strobes %0d expected 3c 00 2", byte_a, {brk_a, ferr_a}, n_dv_a - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [7:0] v;
        v = 8'h81;
        d0 = n_dv_a;
        send_bit(0, 1'b0, -1);
        for (int b = 0; b < 4; b++) send_bit(0, v[b], -1);
        rx[0] = v[4];
        tick(5);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        tick(1);
        rst_n = 1'b1;
        n_checks++;
        if ({dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
            n_errors++; $display("FAIL rst_mid_outputs: got %b expected 0", {dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a});
        end
        tick(3 * CPB);
        n_checks++;
        if (n_dv_a != d0) begin
            n_errors++; $display("FAIL rst_mid_no_strobe: got %0d expected 0", n_dv_a - d0);
        end
        send_frame(0, {1'b0, v}, 8, -1, 1, 1'b1, -1);
        tick(3);
        n_checks++;
        if (byte_a !== 8'h81 || n_dv_a - d0 != 1 || {perr_a, ferr_a, brk_a} !== 3'b000) begin
            n_errors++; $display("FAIL rst_mid_next: got byte %h strobes %0d flags %b expected 81 1 000", byte_a, n_dv_a - d0, {perr_a, ferr_a, brk_a});
        end
    endtask

    initial begin
        rst_n = 1'b1;
        rx[0] = 1'b1; rx[1] = 1'b1; rx[2] = 1'b1;
        tick(1);
        test_reset();
        test_8n1();
        test_parity();
        test_8n2();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
